// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble). Each SHIFT cycle moves one
// input bit into the scratch digits; the result and overflow register on DONE.
module bin2bcd_seq #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int ND = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sr;
  logic [ND-1:0]   scr;
  logic [ND-1:0]   adj;
  logic            ovf;

  // Add-3 per digit, no carry between digits.
  always_comb begin
    adj = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = (scr[4*k +: 4] >= 4'd5) ? scr[4*k +: 4] + 4'd3 : scr[4*k +: 4];
    end
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      scr      <= '0;
      ovf      <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= bin;
            scr   <= '0;
            ovf   <= 1'b0;
            cnt   <= CW'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The bit leaving the top digit would belong to a digit we do not have.
          scr <= {adj[ND-2:0], sr[WIDTH-1]};
          sr  <= sr << 1;
          ovf <= ovf | adj[ND-1];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          bcd      <= scr;
          overflow <= ovf;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq across four parameter sets, with a
// division-based decimal reference for the exhaustive 9-bit sweep.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [8:0]  bin0 = '0, bin1 = '0;
  logic [15:0] bin2 = '0;
  logic [0:0]  bin3 = '0;
  logic        ready0, busy0, done0, ovf0;
  logic        ready1, busy1, done1, ovf1;
  logic        ready2, busy2, done2, ovf2;
  logic        ready3, busy3, done3, ovf3;
  logic [11:0] bcd0;
  logic [7:0]  bcd1;
  logic [19:0] bcd2;
  logic [3:0]  bcd3;

  bin2bcd_seq #(.WIDTH(9), .DIGITS(3)) u0 (.clk(clk), .rst(rst), .start(start0), .bin(bin0),
    .ready(ready0), .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0));
  bin2bcd_seq #(.WIDTH(9), .DIGITS(2)) u1 (.clk(clk), .rst(rst), .start(start1), .bin(bin1),
    .ready(ready1), .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u2 (.clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .ready(ready2), .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2));
  bin2bcd_seq #(.WIDTH(1), .DIGITS(1)) u3 (.clk(clk), .rst(rst), .start(start3), .bin(bin3),
    .ready(ready3), .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_bcd(input int unsigned v, input int d);
    logic [63:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      0: return done0;
      1: return done1;
      2: return done2;
      default: return done3;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0: return busy0;
      1: return busy1;
      2: return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic logic [63:0] get_bcd(input int w);
    case (w)
      0: return 64'(bcd0);
      1: return 64'(bcd1);
      2: return 64'(bcd2);
      default: return 64'(bcd3);
    endcase
  endfunction

  function automatic logic get_ovf(input int w);
    case (w)
      0: return ovf0;
      1: return ovf1;
      2: return ovf2;
      default: return ovf3;
    endcase
  endfunction

  task automatic set_start(input int w, input logic s, input logic [31:0] v);
    case (w)
      0: begin start0 = s; bin0 = v[8:0]; end
      1: begin start1 = s; bin1 = v[8:0]; end
      2: begin start2 = s; bin2 = v[15:0]; end
      default: begin start3 = s; bin3 = v[0:0]; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run(input int w, input logic [31:0] v, output int k, output int bc);
    set_start(w, 1'b1, v);
    @(negedge clk);
    set_start(w, 1'b0, v);
    k = 0;
    bc = 0;
    while (!get_done(w) && k < 60) begin
      if (get_busy(w)) bc++;
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(get_done(w)), 64'd1);
  endtask

  initial begin
    int k, bc, dones;
    logic [63:0] got;

    #1;
    chk("rst_bcd", 64'(bcd0), 64'h0);
    chk("rst_ready", 64'(ready0), 64'd1);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // bin=0: latency and busy length
    run(0, 0, k, bc);
    chk("zero_lat", 64'(k), 64'd10);
    chk("zero_busy", 64'(bc), 64'd10);
    chk("zero_bcd", get_bcd(0), 64'h000);
    chk("zero_ovf", 64'(ovf0), 64'd0);

    // back-to-back, second start in the done cycle
    @(negedge clk);
    run(0, 511, k, bc);
    chk("b2b1_bcd", get_bcd(0), 64'h511);
    chk("b2b1_ovf", 64'(ovf0), 64'd0);
    chk("b2b_ready", 64'(ready0), 64'd1);
    run(0, 255, k, bc);
    chk("b2b2_lat", 64'(k), 64'd10);
    chk("b2b2_bcd", get_bcd(0), 64'h255);
    chk("b2b2_ovf", 64'(ovf0), 64'd0);

    // starts while busy are ignored
    start0 = 1'b1; bin0 = 9'd100;
    @(negedge clk);
    start0 = 1'b0;
    dones = 0;
    got = '0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 3 || i == 7) begin start0 = 1'b1; bin0 = 9'd7; end
      else start0 = 1'b0;
      @(negedge clk);
      if (i == 5) chk("hold_bcd", get_bcd(0), 64'h255);
      if (done0) begin dones++; got = get_bcd(0); end
    end
    start0 = 1'b0;
    chk("ign_dones", 64'(dones), 64'd1);
    chk("ign_bcd", got, 64'h100);

    // asynchronous reset mid-conversion
    start0 = 1'b1; bin0 = 9'd300;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_bcd", 64'(bcd0), 64'h0);
    chk("arst_ready", 64'(ready0), 64'd1);
    chk("arst_busy", 64'(busy0), 64'd0);
    chk("arst_ovf", 64'(ovf0), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    run(0, 42, k, bc);
    chk("arst42_bcd", get_bcd(0), 64'h042);

    // too few digits
    @(negedge clk);
    run(1, 511, k, bc);
    chk("d2_511_bcd", get_bcd(1), 64'h11);
    chk("d2_511_ovf", 64'(ovf1), 64'd1);
    run(1, 99, k, bc);
    chk("d2_99_bcd", get_bcd(1), 64'h99);
    chk("d2_99_ovf", 64'(ovf1), 64'd0);

    // wide operand at its maximum
    run(2, 65535, k, bc);
    chk("w16_lat", 64'(k), 64'd17);
    chk("w16_bcd", get_bcd(2), 64'h65535);
    chk("w16_ovf", 64'(ovf2), 64'd0);

    // single-bit operand
    run(3, 1, k, bc);
    chk("w1_lat", 64'(k), 64'd2);
    chk("w1_bcd", get_bcd(3), 64'h1);

    // exhaustive sweep at default parameters
    for (int v = 0; v < 512; v++) begin
      run(0, 32'(v), k, bc);
      chk("sweep_bcd", get_bcd(0), ref_bcd(v, 3));
      chk("sweep_ovf", 64'(ovf0), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
